// File: rtl/c_write_packer_pkg.sv
// -----------------------------------------------------------------------------
// c_write_packer_pkg
//   Shared definitions for the C-matrix write packer: default widths of the
//   systolic array result path and the packer FSM state type.
// -----------------------------------------------------------------------------
package c_write_packer_pkg;

    // Default result element width, write-bus width (bytes) and address width.
    localparam int C_DATA_WIDTH      = 8;
    localparam int C_BUS_WIDTH_BYTES = 32;
    localparam int C_ADDR_WIDTH      = 16;

    // Packer FSM states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } pack_state_t;

endpackage : c_write_packer_pkg

// File: rtl/c_write_packer.sv
// -----------------------------------------------------------------------------
// c_write_packer
//   Collects result elements drained from the systolic array, packs them one
//   per byte lane into full-width write beats, and issues each beat to the C
//   memory bus with a req/gnt handshake. A partial final beat is written with
//   unused lanes zeroed and their byte enables cleared.
//
// Ports
//   clk          core clock, rising edge
//   reset_n      asynchronous active-low reset
//   start_i      one-cycle start pulse (honoured only in IDLE)
//   base_addr_i  C base byte address, sampled on accepted start
//   count_i      number of elements to write, sampled on accepted start
//   in_valid_i   result element valid
//   in_data_i    result element
//   in_ready_o   element accepted this cycle when in_valid_i is also high
//   mem_req_o    write request (held until granted)
//   mem_we_o     write enable, mirrors mem_req_o
//   mem_addr_o   beat byte address
//   mem_wdata_o  packed beat data, lane k at bits 8k+7:8k
//   mem_be_o     byte enables, one per lane
//   mem_gnt_i    bus accepted the request this cycle
//   busy_o       high from accepted start until the return to IDLE
//   done_o       one-cycle completion pulse
// -----------------------------------------------------------------------------
module c_write_packer
    import c_write_packer_pkg::*;
#(
    parameter int DATA_WIDTH      = C_DATA_WIDTH,
    parameter int BUS_WIDTH_BYTES = C_BUS_WIDTH_BYTES,
    parameter int ADDR_WIDTH      = C_ADDR_WIDTH
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         start_i,
    input  logic [ADDR_WIDTH-1:0]        base_addr_i,
    input  logic [15:0]                  count_i,
    input  logic                         in_valid_i,
    input  logic [DATA_WIDTH-1:0]        in_data_i,
    output logic                         in_ready_o,
    output logic                         mem_req_o,
    output logic                         mem_we_o,
    output logic [ADDR_WIDTH-1:0]        mem_addr_o,
    output logic [8*BUS_WIDTH_BYTES-1:0] mem_wdata_o,
    output logic [BUS_WIDTH_BYTES-1:0]   mem_be_o,
    input  logic                         mem_gnt_i,
    output logic                         busy_o,
    output logic                         done_o
);

    // The lane pointer must be able to count up to BUS_WIDTH_BYTES itself.
    localparam int LANE_W = $clog2(BUS_WIDTH_BYTES + 1);
    localparam int IDX_W  = (BUS_WIDTH_BYTES > 1) ? $clog2(BUS_WIDTH_BYTES) : 1;

    localparam logic [LANE_W-1:0]     LAST_LANE   = LANE_W'(BUS_WIDTH_BYTES - 1);
    localparam logic [ADDR_WIDTH-1:0] BEAT_STRIDE = ADDR_WIDTH'(BUS_WIDTH_BYTES);

    pack_state_t       state;
    logic [LANE_W-1:0] lane_q;
    logic [15:0]       remaining_q;

    logic [7:0]        elem_byte;
    logic [IDX_W-1:0]  lane_idx;
    logic              accept;

    // Each lane is one byte; wider elements are truncated, narrower ones
    // zero-extended.
    assign elem_byte = 8'(in_data_i);
    assign lane_idx  = IDX_W'(lane_q);
    assign accept    = in_valid_i & in_ready_o;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: the beat buffer is plain output flops, not a RAM, so it is
            // cleared on reset; this is also what discards a partial beat.
            state       <= IDLE;
            lane_q      <= '0;
            remaining_q <= '0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            mem_be_o    <= '0;
            in_ready_o  <= 1'b0;
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
        end else begin
            // NOTE: nxt is a block-local temporary written with blocking
            // assignments so the registered outputs below can be decoded from
            // the state being entered; all real state still uses <=.
            pack_state_t nxt;
            nxt = state;

            case (state)
                IDLE: begin
                    if (start_i) begin
                        mem_addr_o  <= base_addr_i;
                        remaining_q <= count_i;
                        lane_q      <= '0;
                        mem_wdata_o <= '0;
                        mem_be_o    <= '0;
                        nxt         = (count_i == 16'd0) ? DONE : FILL;
                    end
                end

                FILL: begin
                    if (accept) begin
                        mem_wdata_o[8*int'(lane_idx) +: 8] <= elem_byte;
                        mem_be_o[lane_idx]                 <= 1'b1;
                        remaining_q                        <= remaining_q - 16'd1;
                        lane_q                             <= lane_q + LANE_W'(1);
                        // Beat closes on the last lane or the last element.
                        if (lane_q == LAST_LANE || remaining_q == 16'd1) begin
                            nxt = WRITE;
                        end
                    end
                end

                WRITE: begin
                    // Request, address, data and enables hold until granted.
                    if (mem_gnt_i) begin
                        mem_addr_o  <= mem_addr_o + BEAT_STRIDE;
                        lane_q      <= '0;
                        mem_wdata_o <= '0;
                        mem_be_o    <= '0;
                        nxt         = (remaining_q != 16'd0) ? FILL : DONE;
                    end
                end

                DONE: begin
                    nxt = IDLE;
                end

                default: begin
                    nxt = IDLE;
                end
            endcase

            state      <= nxt;
            in_ready_o <= (nxt == FILL);
            mem_req_o  <= (nxt == WRITE);
            mem_we_o   <= (nxt == WRITE);
            busy_o     <= (nxt != IDLE);
            done_o     <= (nxt == DONE);
        end
    end

endmodule : c_write_packer

// File: tb/tb_c_write_packer.sv
// -----------------------------------------------------------------------------
// tb_c_write_packer
//   Directed bench for c_write_packer with hand-derived expectations: element
//   values are the running accept index XOR a per-test seed, so every lane of
//   every beat is predictable from the element order alone.
// -----------------------------------------------------------------------------
module tb_c_write_packer;

    localparam int DW   = 8;
    localparam int BWB  = 32;
    localparam int AW   = 16;
    localparam int BUSW = 8 * BWB;

    logic            clk        = 1'b0;
    logic            reset_n    = 1'b0;
    logic            start_i    = 1'b0;
    logic [AW-1:0]   base_addr_i = '0;
    logic [15:0]     count_i    = '0;
    logic            in_valid_i = 1'b0;
    logic [DW-1:0]   in_data_i;
    logic            in_ready_o;
    logic            mem_req_o;
    logic            mem_we_o;
    logic [AW-1:0]   mem_addr_o;
    logic [BUSW-1:0] mem_wdata_o;
    logic [BWB-1:0]  mem_be_o;
    logic            mem_gnt_i  = 1'b0;
    logic            busy_o;
    logic            done_o;

    int tests_run = 0;
    int fail_cnt  = 0;

    c_write_packer #(
        .DATA_WIDTH      (DW),
        .BUS_WIDTH_BYTES (BWB),
        .ADDR_WIDTH      (AW)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start_i     (start_i),
        .base_addr_i (base_addr_i),
        .count_i     (count_i),
        .in_valid_i  (in_valid_i),
        .in_data_i   (in_data_i),
        .in_ready_o  (in_ready_o),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_be_o    (mem_be_o),
        .mem_gnt_i   (mem_gnt_i),
        .busy_o      (busy_o),
        .done_o      (done_o)
    );

    always #5 clk = ~clk;

    // Element source: value = accept index XOR seed.
    int         elem_idx = 0;
    logic [7:0] seed     = 8'h00;
    assign in_data_i = elem_idx[7:0] ^ seed;

    always @(posedge clk) begin
        if (in_valid_i && in_ready_o) elem_idx <= elem_idx + 1;
    end

    // Beat / done monitors.
    logic [AW-1:0]   cap_addr [0:15];
    logic [BUSW-1:0] cap_data [0:15];
    logic [BWB-1:0]  cap_be   [0:15];
    int              beat_cnt = 0;
    int              done_cnt = 0;
    int              we_bad   = 0;

    always @(posedge clk) begin
        if (mem_req_o && mem_gnt_i) begin
            cap_addr[beat_cnt[3:0]] <= mem_addr_o;
            cap_data[beat_cnt[3:0]] <= mem_wdata_o;
            cap_be[beat_cnt[3:0]]   <= mem_be_o;
            beat_cnt                <= beat_cnt + 1;
        end
        if (done_o) done_cnt <= done_cnt + 1;
        if (mem_req_o && !mem_we_o) we_bad <= we_bad + 1;
    end

    task automatic check(input string tag, input logic [BUSW-1:0] got,
                         input logic [BUSW-1:0] exp);
        tests_run++;
        if (got !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [BUSW-1:0] exp_beat(input int first, input int n,
                                                 input logic [7:0] sd);
        logic [BUSW-1:0] r;
        int              v;
        r = '0;
        for (int k = 0; k < BWB; k++) begin
            v = first + k;
            if (k < n) r[8*k +: 8] = v[7:0] ^ sd;
        end
        return r;
    endfunction

    function automatic logic [BWB-1:0] exp_be(input int n);
        logic [BWB-1:0] r;
        r = '0;
        for (int k = 0; k < BWB; k++) begin
            if (k < n) r[k] = 1'b1;
        end
        return r;
    endfunction

    task automatic do_start(input logic [AW-1:0] addr, input logic [15:0] cnt);
        @(negedge clk);
        base_addr_i = addr;
        count_i     = cnt;
        start_i     = 1'b1;
        @(negedge clk);
        start_i     = 1'b0;
    endtask

    // Wait (bounded) for a done pulse, then confirm exactly one and idle.
    task automatic wait_done(input int snap, input string tag);
        int n;
        n = 0;
        while (done_cnt == snap && n < 400) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_done_seen"}, BUSW'(done_cnt != snap), BUSW'(1));
        repeat (3) @(negedge clk);
        check({tag, "_done_once"}, BUSW'(done_cnt - snap), BUSW'(1));
        check({tag, "_idle_busy"}, BUSW'(busy_o), BUSW'(0));
    endtask

    int elem_base;
    int beat_snap;
    int done_snap;

    initial begin
        // ---------------- reset state ----------------
        #1;
        check("rst_ctl", BUSW'({in_ready_o, mem_req_o, mem_we_o, busy_o, done_o}), BUSW'(0));
        check("rst_addr", BUSW'(mem_addr_o), BUSW'(0));
        check("rst_data", mem_wdata_o, '0);
        check("rst_be", BUSW'(mem_be_o), BUSW'(0));
        @(negedge clk);
        @(negedge clk);
        reset_n    = 1'b1;
        in_valid_i = 1'b1;
        mem_gnt_i  = 1'b1;

        // ---------------- T1: two full beats ----------------
        seed = 8'h00;
        elem_base = elem_idx; beat_snap = beat_cnt; done_snap = done_cnt;
        do_start(16'h0100, 16'd64);
        wait_done(done_snap, "t1");
        check("t1_beats", BUSW'(beat_cnt - beat_snap), BUSW'(2));
        check("t1_addr0", BUSW'(cap_addr[beat_snap[3:0]]), BUSW'(16'h0100));
        check("t1_addr1", BUSW'(cap_addr[4'(beat_snap + 1)]), BUSW'(16'h0120));
        check("t1_be0", BUSW'(cap_be[beat_snap[3:0]]), BUSW'(exp_be(32)));
        check("t1_be1", BUSW'(cap_be[4'(beat_snap + 1)]), BUSW'(exp_be(32)));
        check("t1_data0", cap_data[beat_snap[3:0]], exp_beat(elem_base, 32, seed));
        check("t1_data1", cap_data[4'(beat_snap + 1)], exp_beat(elem_base + 32, 32, seed));

        // ---------------- T2: partial last beat ----------------
        seed = 8'h5A;
        elem_base = elem_idx; beat_snap = beat_cnt; done_snap = done_cnt;
        do_start(16'h0200, 16'd40);
        wait_done(done_snap, "t2");
        check("t2_beats", BUSW'(beat_cnt - beat_snap), BUSW'(2));
        check("t2_addr0", BUSW'(cap_addr[beat_snap[3:0]]), BUSW'(16'h0200));
        check("t2_addr1", BUSW'(cap_addr[4'(beat_snap + 1)]), BUSW'(16'h0220));
        check("t2_be0", BUSW'(cap_be[beat_snap[3:0]]), BUSW'(32'hFFFF_FFFF));
        check("t2_be1", BUSW'(cap_be[4'(beat_snap + 1)]), BUSW'(32'h0000_00FF));
        check("t2_data0", cap_data[beat_snap[3:0]], exp_beat(elem_base, 32, seed));
        check("t2_data1", cap_data[4'(beat_snap + 1)], exp_beat(elem_base + 32, 8, seed));

        // ---------------- T3: grant stall ----------------
        seed = 8'hC3;
        mem_gnt_i = 1'b0;
        elem_base = elem_idx; beat_snap = beat_cnt; done_snap = done_cnt;
        do_start(16'h0400, 16'd32);
        begin
            int n;
            n = 0;
            while (!mem_req_o && n < 100) begin
                @(negedge clk);
                n++;
            end
        end
        check("t3_req_seen", BUSW'(mem_req_o), BUSW'(1));
        for (int i = 0; i < 6; i++) begin
            check($sformatf("t3_req_c%0d", i), BUSW'(mem_req_o), BUSW'(1));
            check($sformatf("t3_rdy_c%0d", i), BUSW'(in_ready_o), BUSW'(0));
            check($sformatf("t3_addr_c%0d", i), BUSW'(mem_addr_o), BUSW'(16'h0400));
            check($sformatf("t3_be_c%0d", i), BUSW'(mem_be_o), BUSW'(32'hFFFF_FFFF));
            check($sformatf("t3_data_c%0d", i), mem_wdata_o, exp_beat(elem_base, 32, seed));
            if (i == 5) mem_gnt_i = 1'b1;
            @(negedge clk);
        end
        check("t3_req_drop", BUSW'(mem_req_o), BUSW'(0));
        check("t3_done_now", BUSW'(done_o), BUSW'(1));
        wait_done(done_snap, "t3");
        check("t3_beats", BUSW'(beat_cnt - beat_snap), BUSW'(1));

        // ---------------- T4: count = 0 ----------------
        beat_snap = beat_cnt; done_snap = done_cnt;
        do_start(16'h0600, 16'd0);
        check("t4_done_hi", BUSW'(done_o), BUSW'(1));
        check("t4_busy_hi", BUSW'(busy_o), BUSW'(1));
        check("t4_no_req", BUSW'(mem_req_o), BUSW'(0));
        @(negedge clk);
        check("t4_done_lo", BUSW'(done_o), BUSW'(0));
        check("t4_busy_lo", BUSW'(busy_o), BUSW'(0));
        check("t4_beats", BUSW'(beat_cnt - beat_snap), BUSW'(0));
        check("t4_done_cnt", BUSW'(done_cnt - done_snap), BUSW'(1));

        // ---------------- T5: address wrap, stray start ----------------
        seed = 8'h17;
        elem_base = elem_idx; beat_snap = beat_cnt; done_snap = done_cnt;
        do_start(16'hFFF0, 16'd64);
        repeat (10) @(negedge clk);
        base_addr_i = 16'h1234;
        count_i     = 16'd5;
        start_i     = 1'b1;
        @(negedge clk);
        start_i     = 1'b0;
        wait_done(done_snap, "t5");
        check("t5_beats", BUSW'(beat_cnt - beat_snap), BUSW'(2));
        check("t5_addr0", BUSW'(cap_addr[beat_snap[3:0]]), BUSW'(16'hFFF0));
        check("t5_addr1", BUSW'(cap_addr[4'(beat_snap + 1)]), BUSW'(16'h0010));
        check("t5_data1", cap_data[4'(beat_snap + 1)], exp_beat(elem_base + 32, 32, seed));

        // ---------------- T6: reset mid-beat ----------------
        seed = 8'h33;
        elem_base = elem_idx; beat_snap = beat_cnt;
        do_start(16'h0500, 16'd64);
        begin
            int n;
            n = 0;
            while ((elem_idx - elem_base) < 10 && n < 100) begin
                @(negedge clk);
                n++;
            end
        end
        check("t6_ten_elems", BUSW'(elem_idx - elem_base), BUSW'(10));
        #2 reset_n = 1'b0;
        #1;
        check("t6_rst_ctl", BUSW'({in_ready_o, mem_req_o, mem_we_o, busy_o, done_o}), BUSW'(0));
        check("t6_rst_addr", BUSW'(mem_addr_o), BUSW'(0));
        check("t6_rst_data", mem_wdata_o, '0);
        check("t6_rst_be", BUSW'(mem_be_o), BUSW'(0));
        @(negedge clk);
        reset_n = 1'b1;
        check("t6_no_beat", BUSW'(beat_cnt - beat_snap), BUSW'(0));
        seed = 8'hA5;
        elem_base = elem_idx; beat_snap = beat_cnt; done_snap = done_cnt;
        do_start(16'h0300, 16'd32);
        wait_done(done_snap, "t6");
        check("t6_beats", BUSW'(beat_cnt - beat_snap), BUSW'(1));
        check("t6_addr0", BUSW'(cap_addr[beat_snap[3:0]]), BUSW'(16'h0300));
        check("t6_be0", BUSW'(cap_be[beat_snap[3:0]]), BUSW'(32'hFFFF_FFFF));
        check("t6_data0", cap_data[beat_snap[3:0]], exp_beat(elem_base, 32, seed));

        check("we_follows_req", BUSW'(we_bad), BUSW'(0));

        $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_c_write_packer

// File: doc/c_write_packer.md
C_WRITE_PACKER -- requirements
Module: c_write_packer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning result element width in bits.
REQ-002 SHALL have parameter BUS_WIDTH_BYTES, default 32, meaning write-bus width in bytes (lanes per beat).
REQ-003 SHALL have parameter ADDR_WIDTH, default 16, meaning byte-address width.
REQ-004 SHALL have clk  input  1  core clock; one clock only; all logic rising-edge.
REQ-005 SHALL have reset_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have start_i  input  1  one-cycle start pulse from the array control.
REQ-007 SHALL have base_addr_i  input  ADDR_WIDTH  matrix C base byte address, sampled on accepted start.
REQ-008 SHALL have count_i  input  16  number of C elements to write, sampled on accepted start.
REQ-009 SHALL have in_valid_i  input  1  result element valid from systolic array drain.
REQ-010 SHALL have in_data_i  input  DATA_WIDTH  result element.
REQ-011 SHALL have in_ready_o  output  1  packer accepts element this cycle.
REQ-012 SHALL have mem_req_o  output  1  write request to C memory bus.
REQ-013 SHALL have mem_we_o  output  1  write enable; high whenever mem_req_o is high.
REQ-014 SHALL have mem_addr_o  output  ADDR_WIDTH  beat byte address.
REQ-015 SHALL have mem_wdata_o  output  8*BUS_WIDTH_BYTES  packed beat data.
REQ-016 SHALL have mem_be_o  output  BUS_WIDTH_BYTES  byte enables.
REQ-017 SHALL have mem_gnt_i  input  1  bus accepted the request this cycle.
REQ-018 SHALL have busy_o  output  1  high from accepted start until done.
REQ-019 SHALL have done_o  output  1  one-cycle completion pulse (feeds operation_done).

Function
REQ-020 SHALL implement FSM states IDLE, FILL, WRITE, DONE.
REQ-021 SHALL, in IDLE with start_i=1, latch base_addr_i/count_i, clear lane pointer, go to FILL (count_i=0: go to DONE, no writes).
REQ-022 SHALL ignore start_i in any state other than IDLE.
REQ-023 SHALL assert in_ready_o only in FILL; element accepted when in_valid_i & in_ready_o.
REQ-024 SHALL place the k-th accepted element of a beat in lane k (bits 8k+7:8k), set mem_be_o[k], decrement remaining count, increment lane pointer.
REQ-025 SHALL move FILL->WRITE on the cycle after the lane pointer reaches BUS_WIDTH_BYTES or remaining count reaches 0; in_ready_o low from that cycle.
REQ-026 SHALL in WRITE hold mem_req_o=1 with stable addr/wdata/be until mem_gnt_i=1 (no request withdrawal).
REQ-027 SHALL on grant: address += BUS_WIDTH_BYTES modulo 2^ADDR_WIDTH, clear lanes/be/data to 0, go to FILL if remaining>0 else DONE.
REQ-028 SHALL drive unfilled lanes of a partial last beat as data 0, be 0.
REQ-029 SHALL in DONE assert done_o for exactly one cycle, then return to IDLE; busy_o low in IDLE only.
REQ-030 SHALL keep mem_req_o low outside WRITE; grant outside WRITE ignored.
REQ-031 SHALL accept mem_gnt_i in the same cycle mem_req_o first rises (zero-wait grant).

Reset
REQ-032 SHALL on reset_n low, at any time including mid-beat, force IDLE; in_ready_o, mem_req_o, mem_we_o, busy_o, done_o = 0; addr, wdata, be, counters = 0; partial beat discarded.

Structure
REQ-033 SHALL take FSM state enum and default widths from the shared systolic package (state typedef, BUS_WIDTH_BYTES, DATA_WIDTH).
REQ-034 SHALL be a single module; no sub-module required.

Verification
REQ-035 SHALL cover: base=0x0100, count=64, valid always, gnt immediate -> two beats at 0x0100, 0x0120, be=all ones, lane k = k-th element, one done pulse.
REQ-036 SHALL cover: count=40 -> beats at base and base+32, second be=0x000000FF, lanes 8..31 data 0.
REQ-037 SHALL cover: gnt held low 5 cycles in WRITE -> req/addr/data/be stable for 6 cycles, in_ready_o low throughout.
REQ-038 SHALL cover: count=0 -> no mem_req_o, done_o one cycle after start, busy_o one cycle.
REQ-039 SHALL cover: base=0xFFF0, count=64 -> second beat address 0x0010 (wrap); start_i pulse mid-op ignored.
REQ-040 SHALL cover: reset_n low after 10 elements accepted -> all outputs 0 asynchronously; new start afterwards produces clean first beat.
